// File: rtl/enc_pkg.sv
// Shared constants and width helper for the registered request encoder.
package enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Index width for n sources; a single source still needs one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pri_select.sv
// Combinational find-first-set starting at a given pointer, wrapping modulo N.
module pri_select #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [N-1:0] sel,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [N-1:0] rot;
  int           first;
  int           abs_idx;

  // Rotate so 'start' sits at bit 0, pick the lowest set bit, then map back.
  always_comb begin
    rot     = '0;
    first   = 0;
    abs_idx = 0;
    any     = 1'b0;
    sel     = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = vec[(i + int'(start)) % N];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        first = i;
        any   = 1'b1;
      end
    end
    abs_idx = (first + int'(start)) % N;
    if (any) begin
      sel[abs_idx] = 1'b1;
      idx          = abs_idx[W-1:0];
    end
  end

endmodule

// File: rtl/req_encoder.sv
// Registered request encoder: captures pulse/level requests and issues them one at a time.
// Optional coalesce statistics counter is enabled with `define REQ_ENCODER_STATS_EN.
module req_encoder
  import enc_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int MODE = MODE_FIXED,
  localparam int W    = clog2_min1(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         busy,
  output logic [15:0]  coalesce_cnt
);

  logic [N-1:0] pending;
  logic [W-1:0] rr_ptr;
  logic [N-1:0] eff;
  logic [W-1:0] start;
  logic [N-1:0] sel;
  logic [W-1:0] sel_idx;
  logic         sel_any;
  logic         load;

  assign eff = pending | req;

  // Round-robin searches from just past the last grant; fixed priority always from 0.
  generate
    if (MODE == MODE_RR && N > 1) begin : g_rr_start
      assign start = (rr_ptr == W'(N - 1)) ? '0 : rr_ptr + W'(1);
    end else begin : g_fixed_start
      assign start = '0;
    end
  endgenerate

  pri_select #(.N(N), .W(W)) u_sel (
    .vec   (eff),
    .start (start),
    .sel   (sel),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  assign load = (!out_valid || out_ready) && sel_any;
  assign busy = out_valid | (|pending);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      rr_ptr     <= W'(N - 1);
    end else if (load) begin
      out_idx    <= sel_idx;
      out_onehot <= sel;
      out_valid  <= 1'b1;
      pending    <= eff & ~sel;
      rr_ptr     <= sel_idx;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
      out_onehot <= '0;
      pending    <= eff;
    end else begin
      pending    <= eff;
    end
  end

`ifdef REQ_ENCODER_STATS_EN
  logic       hit;
  logic [15:0] cnt;

  // A request merging into an entry that is already pending or stalled in the output.
  assign hit = (|(req & pending)) || (out_valid && !out_ready && (|(req & out_onehot)));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (hit && cnt != 16'hFFFF) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign coalesce_cnt = cnt;
`else
  assign coalesce_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_req_encoder.sv
// Bench for req_encoder: fixed and round-robin instances against a behavioural model.
module tb_req_encoder;
  import enc_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         out_ready;

  logic         f_valid, r_valid;
  logic [2:0]   f_idx, r_idx;
  logic [N-1:0] f_onehot, r_onehot;
  logic         f_busy, r_busy;
  logic [15:0]  f_cnt, r_cnt;

  int checks = 0;
  int passes = 0;

  // Model state, index 0 = fixed priority, 1 = round robin.
  int m_pend  [2][N];
  bit m_valid [2];
  int m_idx   [2];
  int m_rr    [2];
  int m_cnt   [2];

  always #5 clk = ~clk;

  req_encoder #(.N(N), .MODE(MODE_FIXED)) dut_fixed (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .out_valid    (f_valid),
    .out_ready    (out_ready),
    .out_idx      (f_idx),
    .out_onehot   (f_onehot),
    .busy         (f_busy),
    .coalesce_cnt (f_cnt)
  );

  req_encoder #(.N(N), .MODE(MODE_RR)) dut_rr (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .out_valid    (r_valid),
    .out_ready    (out_ready),
    .out_idx      (r_idx),
    .out_onehot   (r_onehot),
    .busy         (r_busy),
    .coalesce_cnt (r_cnt)
  );

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passes++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < N; i++) m_pend[m][i] = 0;
      m_valid[m] = 0;
      m_idx[m]   = 0;
      m_rr[m]    = N - 1;
      m_cnt[m]   = 0;
    end
  endtask

  // One clock of the encoder rules, using the inputs present at the edge.
  task automatic model_step(input int m);
    int eff[N];
    bit hit;
    int found;
    int i;
    hit = 0;
    for (int k = 0; k < N; k++) begin
      eff[k] = (m_pend[m][k] != 0 || req[k]) ? 1 : 0;
      if (req[k] && m_pend[m][k] != 0) hit = 1;
      if (req[k] && m_valid[m] && !out_ready && m_idx[m] == k) hit = 1;
    end
    if (hit && m_cnt[m] < 65535) m_cnt[m]++;
    found = -1;
    if (!m_valid[m] || out_ready) begin
      for (int k = 0; k < N; k++) begin
        i = (m == 1) ? (m_rr[m] + 1 + k) % N : k;
        if (found < 0 && eff[i] != 0) found = i;
      end
    end
    if (found >= 0) begin
      m_valid[m] = 1;
      m_idx[m]   = found;
      m_rr[m]    = found;
      eff[found] = 0;
    end else if (m_valid[m] && out_ready) begin
      m_valid[m] = 0;
    end
    for (int k = 0; k < N; k++) m_pend[m][k] = eff[k];
  endtask

  function automatic int exp_onehot(input int m);
    return m_valid[m] ? (1 << m_idx[m]) : 0;
  endfunction

  function automatic int exp_busy(input int m);
    int any;
    any = 0;
    for (int k = 0; k < N; k++) if (m_pend[m][k] != 0) any = 1;
    return (m_valid[m] || any != 0) ? 1 : 0;
  endfunction

  function automatic int exp_cnt(input int m);
`ifdef REQ_ENCODER_STATS_EN
    return m_cnt[m];
`else
    return (m >= 0) ? 0 : 0;
`endif
  endfunction

  task automatic check_all();
    checkOutput("fix_valid",  int'(f_valid),  int'(m_valid[0]));
    checkOutput("fix_onehot", int'(f_onehot), exp_onehot(0));
    checkOutput("fix_busy",   int'(f_busy),   exp_busy(0));
    checkOutput("fix_cnt",    int'(f_cnt),    exp_cnt(0));
    if (m_valid[0]) checkOutput("fix_idx", int'(f_idx), m_idx[0]);
    checkOutput("rr_valid",   int'(r_valid),  int'(m_valid[1]));
    checkOutput("rr_onehot",  int'(r_onehot), exp_onehot(1));
    checkOutput("rr_busy",    int'(r_busy),   exp_busy(1));
    checkOutput("rr_cnt",     int'(r_cnt),    exp_cnt(1));
    if (m_valid[1]) checkOutput("rr_idx", int'(r_idx), m_idx[1]);
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic rdy, input logic rs);
    @(negedge clk);
    req       = r;
    out_ready = rdy;
    rst       = rs;
    @(posedge clk);
    if (rs) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    #1;
    check_all();
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    out_ready = 1'b0;
    model_reset();

    // Reset with all requests asserted, then release idle.
    applyStimulus(8'hFF, 1'b0, 1'b1);
    applyStimulus(8'hFF, 1'b0, 1'b1);
    checkOutput("rst_busy", int'(f_busy), 0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("idle_valid", int'(f_valid), 0);

    // Fixed priority pulse: 2, 5, 7 then idle.
    applyStimulus(8'b1010_0100, 1'b1, 1'b0);
    checkOutput("fix_seq0", int'(f_idx), 2);
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("fix_seq1", int'(f_idx), 5);
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("fix_seq2", int'(f_idx), 7);
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("fix_seq_end", int'(f_valid), 0);

    // Backpressure: output held while new request accumulates.
    applyStimulus(8'h01, 1'b0, 1'b0);
    applyStimulus(8'h80, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(8'h00, 1'b0, 1'b0);
      checkOutput("bp_hold", int'(f_idx), 0);
    end
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("bp_next", int'(f_idx), 7);
    applyStimulus(8'h00, 1'b1, 1'b0);

    // Round robin with every request held.
    applyStimulus(8'h00, 1'b1, 1'b1);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(8'hFF, 1'b1, 1'b0);
      checkOutput("rr_cycle", int'(r_idx), c % N);
    end
    applyStimulus(8'h00, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) applyStimulus(8'hFF, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) applyStimulus(8'h81, 1'b1, 1'b0);
    for (int c = 0; c < 10; c++) applyStimulus(8'h00, 1'b1, 1'b0);

    // Coalescing while stalled.
    applyStimulus(8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) applyStimulus(8'h04, 1'b0, 1'b0);
`ifdef REQ_ENCODER_STATS_EN
    checkOutput("coal_cnt", int'(f_cnt), 3);
`else
    checkOutput("coal_cnt", int'(f_cnt), 0);
`endif
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("coal_reissue", int'(f_idx), 2);
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("coal_done", int'(f_valid), 0);

    // Reset mid-stream discards in-flight and pending work.
    applyStimulus(8'h01, 1'b0, 1'b0);
    applyStimulus(8'h0E, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b1);
    checkOutput("mid_rst_valid", int'(f_valid), 0);
    checkOutput("mid_rst_busy", int'(f_busy), 0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(8'h00, 1'b1, 1'b0);
      checkOutput("mid_rst_quiet", int'(f_valid), 0);
    end

    // Randomised traffic with occasional reset and backpressure.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(N'($urandom & $urandom & $urandom), 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 49) == 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
